// File: rtl/serial_add_ctrl_pkg.sv
// Shared declarations for the bit-serial adder controller.
// Holds the FSM state encoding used by the top level.
package serial_add_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/serial_add_ctrl_fa_cell.sv
// One-bit full adder built from two half adders plus an OR of their carries.
// Purely combinational; shared across all bit positions by the controller.
module fa_cell (
   output logic s,
   output logic co,
   input  logic x,
   input  logic y,
   input  logic ci
);

   logic w_s1;
   logic w_c1;
   logic w_c2;

   assign w_s1 = x ^ y;
   assign w_c1 = x & y;
   assign s    = w_s1 ^ ci;
   assign w_c2 = w_s1 & ci;
   assign co   = w_c1 | w_c2;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: sequences one full-adder cell over WIDTH-bit operands,
// LSB first, one bit per clock, and presents a registered {cout,sum} with a done pulse.
module serial_add_ctrl
   import serial_add_ctrl_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int            CW   = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t             r_state;
   state_t             w_next;
   logic [WIDTH-1:0]   r_sa;
   logic [WIDTH-1:0]   r_sb;
   logic [WIDTH-2:0]   r_acc;
   logic               r_cy;
   logic [CW-1:0]      r_cnt;
   logic [WIDTH-1:0]   r_sum;
   logic               r_cout;
   logic               w_s;
   logic               w_co;
   logic               w_last;
   logic [WIDTH-1:0]   w_shift;

   fa_cell u_fa (
      .s  (w_s),
      .co (w_co),
      .x  (r_sa[0]),
      .y  (r_sb[0]),
      .ci (r_cy)
   );

   assign w_last  = (r_cnt == LAST);
   // Accumulator shifted with the new bit at the MSB; the full word is the final sum
   assign w_shift = {w_s, r_acc};

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = ST_IDLE;
      case (r_state)
         ST_IDLE: w_next = start ? ST_RUN : ST_IDLE;
         ST_RUN:  w_next = w_last ? ST_DONE : ST_RUN;
         ST_DONE: w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   always_comb begin
      busy = (r_state == ST_RUN);
      done = (r_state == ST_DONE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_sa   <= '0;
         r_sb   <= '0;
         r_acc  <= '0;
         r_cy   <= 1'b0;
         r_cnt  <= '0;
         r_sum  <= '0;
         r_cout <= 1'b0;
      end else if (r_state == ST_IDLE && start) begin
         r_sa  <= a;
         r_sb  <= b;
         r_cy  <= cin;
         r_cnt <= '0;
      end else if (r_state == ST_RUN) begin
         r_sa  <= r_sa >> 1;
         r_sb  <= r_sb >> 1;
         r_acc <= w_shift[WIDTH-1:1];
         r_cy  <= w_co;
         r_cnt <= r_cnt + 1'b1;
         if (w_last) begin
            r_sum  <= w_shift;
            r_cout <= w_co;
         end
      end
   end

   assign sum  = r_sum;
   assign cout = r_cout;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: a transaction-level timeline model checked every
// cycle, directed scenarios with literal results, and randomized operand sets.
module tb_serial_add_ctrl;

   localparam int W = 8;

   logic         clk   = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic         cin   = 1'b0;
   logic [W-1:0] a     = '0;
   logic [W-1:0] b     = '0;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;

   int n_cmp = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   serial_add_ctrl #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
   );

   // Timeline model: phase 0 = idle, 1..W = busy cycles, W+1 = done cycle
   int         m_phase   = 0;
   logic [W:0] m_res     = '0;
   logic [W:0] m_pending = '0;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_phase = 0;
         m_res   = '0;
      end else if (m_phase == 0) begin
         if (start) begin
            m_pending = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
            m_phase   = 1;
         end
      end else if (m_phase == W) begin
         m_res   = m_pending;
         m_phase = W + 1;
      end else if (m_phase == W + 1) begin
         m_phase = 0;
      end else begin
         m_phase = m_phase + 1;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("busy", 32'(busy), 32'(m_phase >= 1 && m_phase <= W));
         check("done", 32'(done), 32'(m_phase == W + 1));
         check("sum",  32'(sum),  32'(m_res[W-1:0]));
         check("cout", 32'(cout), 32'(m_res[W]));
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Drive operands with start for exactly one edge (the accept edge)
   task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
      a     = x;
      b     = y;
      cin   = c;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Returns at the negedge where done is high; reports the number of cycles waited
   task automatic wait_done(output int cycles);
      cycles = 0;
      for (int i = 0; i < 4 * W; i++) begin
         @(negedge clk);
         cycles++;
         if (done) return;
      end
      check("done_timeout", 32'd0, 32'd1);
   endtask

   int cyc;
   int done_edges[$];
   int edge_no;
   logic [W-1:0] ra, rb;
   logic         rc;
   logic [W:0]   exp_full;

   initial begin
      // Reset state
      rst_n = 1'b0;
      tick(1);
      chk_en = 1'b1;
      tick(2);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_sum",  32'(sum),  32'd0);
      check("rst_cout", 32'(cout), 32'd0);
      rst_n = 1'b1;
      tick(2);

      // 1: zeros, latency and busy length
      start_op(8'h00, 8'h00, 1'b0);
      check("t1_busy_after_accept", 32'(busy), 32'd1);
      wait_done(cyc);
      check("t1_latency", 32'(cyc), 32'(W));
      check("t1_sum",  32'(sum),  32'h00);
      check("t1_cout", 32'(cout), 32'd0);
      tick(1);
      check("t1_done_gone", 32'(done), 32'd0);

      // 2: carry out of the top bit, and carry into the MSB
      start_op(8'hFF, 8'h01, 1'b0);
      wait_done(cyc);
      check("t2a_sum",  32'(sum),  32'h00);
      check("t2a_cout", 32'(cout), 32'd1);
      tick(1);
      start_op(8'h7F, 8'h01, 1'b0);
      wait_done(cyc);
      check("t2b_sum",  32'(sum),  32'h80);
      check("t2b_cout", 32'(cout), 32'd0);
      tick(1);

      // 3: carry-in rippling through all bits; operands changed during RUN
      start_op(8'hA5, 8'h5A, 1'b1);
      a = 8'h33; b = 8'hC4; cin = 1'b0;
      tick(3);
      check("t3_prior_held", 32'(sum), 32'h80);
      wait_done(cyc);
      check("t3_sum",  32'(sum),  32'h00);
      check("t3_cout", 32'(cout), 32'd1);
      tick(1);

      // 4: start pulse at edge 4 ignored
      start_op(8'h12, 8'h34, 1'b0);
      tick(2);
      start = 1'b1; a = 8'hFF; b = 8'hFF;
      tick(1);
      start = 1'b0;
      wait_done(cyc);
      check("t4_sum", 32'(sum), 32'h46);
      check("t4_latency", 32'(cyc), 32'(W - 3));
      for (int i = 0; i < 2 * W; i++) begin
         @(negedge clk);
         check("t4_no_second_done", 32'(done), 32'd0);
      end

      // 5: reset at edge 5 aborts
      start_op(8'h0F, 8'h01, 1'b0);
      tick(3);
      rst_n = 1'b0;
      tick(1);
      rst_n = 1'b1;
      check("t5_busy", 32'(busy), 32'd0);
      check("t5_sum",  32'(sum),  32'd0);
      check("t5_cout", 32'(cout), 32'd0);
      for (int i = 0; i < 2 * W; i++) begin
         @(negedge clk);
         check("t5_no_done", 32'(done), 32'd0);
      end
      start_op(8'h0F, 8'h01, 1'b0);
      wait_done(cyc);
      check("t5_restart_sum", 32'(sum), 32'h10);
      tick(1);

      // 6: start held high; done every W+2 edges
      a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
      edge_no = 0;
      for (int i = 0; i < 5 * (W + 2); i++) begin
         @(negedge clk);
         edge_no++;
         if (done) begin
            done_edges.push_back(edge_no);
            check("t6_sum", 32'(sum), 32'h30);
         end
      end
      start = 1'b0;
      check("t6_count", 32'(done_edges.size()), 32'd5);
      for (int i = 1; i < done_edges.size(); i++)
         check("t6_period", 32'(done_edges[i] - done_edges[i-1]), 32'(W + 2));
      tick(W + 3);

      // Random operand sets, with input noise during RUN
      for (int n = 0; n < 1000; n++) begin
         ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
         exp_full = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
         start_op(ra, rb, rc);
         a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
         if ($urandom_range(0, 3) == 0) begin
            start = 1'b1;
            tick(1);
            start = 1'b0;
         end
         wait_done(cyc);
         check("rand_result", 32'({cout, sum}), 32'(exp_full));
         tick($urandom_range(1, 2));
      end

      tick(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
